seq_addsub_64: RTL and testbench

- Multi-cycle 64-bit adder/subtractor that processes the operand in SLICE-bit chunks, one chunk per clock, chaining carry/borrow through a register.
- Complements the single-cycle parallel-prefix adders. It serves area-constrained datapaths and computes the inverse operation (subtraction) as well as addition.
- Operands enter on a valid/ready input port. Results and flags leave on a valid/ready output port.

---
 rtl/seq_addsub_64.sv | 136 +++++++++++++
 tb/tb_seq_addsub_64.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_64.sv
// Multi-cycle adder/subtractor: one SLICE-bit chunk per clock,
// carry/borrow chained through a register, valid/ready on both sides.
module seq_addsub_64 #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] sa, sb, ss;
  logic             sc;
  logic             last;
  logic             accept;

  assign sa = a_q[cnt_q*SLICE +: SLICE];
  assign sb = b_q[cnt_q*SLICE +: SLICE];
  assign {sc, ss} = {1'b0, sa} + {1'b0, sb}
                  + {{SLICE{1'b0}}, carry_q};

  assign last   = (cnt_q == CW'(NSLICE - 1));
  assign accept = in_valid & in_ready;

  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          sub_d   = sub;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[cnt_q*SLICE +: SLICE] = ss;
        carry_d = sc;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // Same-sign operands giving a different-sign result
          // is exactly carry-in(msb) xor carry-out(msb).
          cout_d  = sc ^ sub_q;
          ovf_d   = (sa[SLICE-1] == sb[SLICE-1])
                  & (ss[SLICE-1] != sa[SLICE-1]);
          zero_d  = (sum_d == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_addsub_64.sv
// Scoreboard bench for seq_addsub_64: directed vectors, random
// back-to-back traffic, backpressure and reset abort.
module tb_seq_addsub_64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        cout, ovf, zero, busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        s;
    res_t        lit;
  } vec_t;

  res_t exp_q[$];

  seq_addsub_64 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic res_t model(
    input logic [63:0] x, input logic [63:0] y,
    input logic ci, input logic s);
    res_t r;
    logic [64:0] full;
    logic signed [66:0] sr;
    if (s) full = {1'b0, x} - {1'b0, y} - {64'd0, ci};
    else   full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    if (s) sr = $signed({{3{x[63]}}, x}) - $signed({{3{y[63]}}, y})
              - $signed({66'd0, ci});
    else   sr = $signed({{3{x[63]}}, x}) + $signed({{3{y[63]}}, y})
              + $signed({66'd0, ci});
    r.sum  = full[63:0];
    r.cout = full[64];
    r.ovf  = (sr[66:63] != {4{sr[63]}});
    r.zero = (full[63:0] == 64'd0);
    return r;
  endfunction

  task automatic send_op(
    input logic [63:0] x, input logic [63:0] y,
    input logic ci, input logic s, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a = x; b = y; cin = ci; sub = s;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      exp_q.push_back(model(x, y, ci, s));
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({sum, cout, ovf, zero, out_valid, busy} !== 69'd0) begin
      failures++;
      $display("FAIL reset_outputs got sum=%h c=%b v=%b z=%b ov=%b bz=%b exp all 0",
               sum, cout, ovf, zero, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release got rdy/ov/busy=%b exp=100",
               {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_arith();
    vec_t t [9];
    bit   ok;
    int   lat;
    res_t e, got;
    t = '{
      '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
        '{64'h0, 1'b1, 1'b0, 1'b1}},
      '{64'h5, 64'h7, 1'b0, 1'b1,
        '{64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0}},
      '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
        '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}},
      '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
        '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0}},
      '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
        '{64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0}},
      '{64'h0000_0000_0001_0000, 64'h0, 1'b1, 1'b1,
        '{64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0}},
      '{64'h0, 64'h0, 1'b0, 1'b1,
        '{64'h0, 1'b0, 1'b0, 1'b1}},
      '{64'h0, 64'h0, 1'b1, 1'b1,
        '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0}},
      '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
        '{64'h0, 1'b1, 1'b0, 1'b1}}
    };
    for (int i = 0; i < 9; i++) begin
      send_op(t[i].a, t[i].b, t[i].ci, t[i].s, ok);
      wait_out(lat);
      checks++;
      if (!ok || lat != 4) begin
        failures++;
        $display("FAIL arith_latency[%0d] got=%0d exp=4 acc=%0b",
                 i, lat, ok);
      end
      got = {sum, cout, ovf, zero};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL arith_model[%0d] got=%h/%b%b%b exp=%h/%b%b%b",
                   i, got.sum, got.cout, got.ovf, got.zero,
                   e.sum, e.cout, e.ovf, e.zero);
        end
      end
      checks++;
      if (got !== t[i].lit) begin
        failures++;
        $display("FAIL arith_const[%0d] got=%h/%b%b%b exp=%h/%b%b%b",
                 i, got.sum, got.cout, got.ovf, got.zero,
                 t[i].lit.sum, t[i].lit.cout, t[i].lit.ovf,
                 t[i].lit.zero);
      end
      if (out_valid) take();
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 20;
    out_ready = 1'b1;
    fork
      begin
        bit ok;
        logic [63:0] x, y;
        for (int k = 0; k < N; k++) begin
          x = {$urandom, $urandom};
          y = {$urandom, $urandom};
          if (k % 4 == 1) y = ~x;
          if (k % 4 == 2) x = x | 64'h0000_FFFF_FFFF_FFFF;
          send_op(x, y, 1'($urandom), 1'($urandom), ok);
        end
      end
      begin
        int lat;
        res_t e, got;
        for (int k = 0; k < N; k++) begin
          wait_out(lat);
          checks++;
          if (lat < 0 || exp_q.size() == 0) begin
            failures++;
            $display("FAIL b2b_timeout[%0d] got lat=%0d exp result",
                     k, lat);
            break;
          end
          e = exp_q.pop_front();
          got = {sum, cout, ovf, zero};
          if (got !== e || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result[%0d] got=%h/%b%b%b rdy=%b exp=%h/%b%b%b rdy=0",
                     k, got.sum, got.cout, got.ovf, got.zero, in_ready,
                     e.sum, e.cout, e.ovf, e.zero);
          end
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   lat;
    res_t e, got;
    send_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
            1'b1, 1'b0, ok);
    wait_out(lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < 10; i++) begin
      got = {sum, cout, ovf, zero};
      checks++;
      if (!ok || got !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%h/%b%b%b ov=%b rdy=%b exp=%h/%b%b%b ov=1 rdy=0",
                 i, got.sum, got.cout, got.ovf, got.zero, out_valid,
                 in_ready, e.sum, e.cout, e.ovf, e.zero);
      end
      if (i == 2) begin
        in_valid = 1'b1;
        a = 64'hAAAA_AAAA_AAAA_AAAA;
        b = 64'h5555_5555_5555_5555;
      end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
    end
    take();
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL bp_release got ov/rdy/busy=%b exp=010",
               {out_valid, in_ready, busy});
    end
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || busy) lat++;
    end
    checks++;
    if (lat != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_not_queued got busy_cycles=%0d q=%0d exp 0 0",
               lat, exp_q.size());
    end
  endtask

  task automatic test_reset_midop();
    bit   ok;
    int   lat;
    int   seen;
    res_t e;
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            1'b1, 1'b0, ok);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sum, cout, ovf, zero, out_valid, busy, in_ready} !== 70'd0) begin
      failures++;
      $display("FAIL midop_reset got sum=%h c=%b v=%b z=%b ov=%b bz=%b rdy=%b exp all 0",
               sum, cout, ovf, zero, out_valid, busy, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_ready got=%b exp=1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midop_no_valid got=%0d exp=0", seen);
    end
    send_op(64'd3, 64'd4, 1'b0, 1'b0, ok);
    wait_out(lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (lat != 4 || sum !== 64'd7 || {sum, cout, ovf, zero} !== e) begin
      failures++;
      $display("FAIL midop_next got lat=%0d sum=%h exp lat=4 sum=7",
               lat, sum);
    end
    if (out_valid) take();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
